// File: rtl/spi_reg_ctrl.sv
// Register-bank controller behind the SPI slave: detects frame end on cs_n, decodes read/write frames.
// Optional watchdog (clears masked registers on expiry) enabled with `define SPI_WDT_EN.
module spi_reg_ctrl #(
    parameter int          NUM_REGS     = 8,
    parameter int unsigned WDT_CYCLES   = 50000,
    parameter logic [127:0] WDT_CLR_MASK = 128'hFF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cs_n,
    input  logic [15:0]           shadow_reg,
    output logic [NUM_REGS*8-1:0] reg_out,
    output logic [NUM_REGS-1:0]   wr_strobe,
    output logic [7:0]            rd_data,
    output logic [7:0]            frame_cnt,
    output logic                  addr_err,
    output logic                  ovr_err,
    output logic                  wdt_timeout
);

    typedef enum logic [1:0] {IDLE, CAPTURE, EXEC} state_t;

    state_t                state_q, state_d;
    logic                  s1_q, s2_q, s3_q;
    logic                  frame_end;
    logic [15:0]           frame_q, frame_d;
    logic [NUM_REGS*8-1:0] bank_q, bank_d;
    logic [NUM_REGS-1:0]   strobe_q, strobe_d;
    logic [7:0]            rd_q, rd_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  aerr_q, aerr_d;
    logic                  ovr_q, ovr_d;
    logic                  valid_wr;
    logic                  wdt_expire;
    logic                  frame_rw;
    logic [6:0]            frame_addr;
    logic [7:0]            frame_data;

    assign frame_rw   = frame_q[15];
    assign frame_addr = frame_q[14:8];
    assign frame_data = frame_q[7:0];

    // Sync flops preset to 1 so reset release with cs_n high never looks like a rising edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= cs_n;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign frame_end = s2_q & ~s3_q;

    // frame_q loads on entry to CAPTURE; the operation is registered on the CAPTURE->EXEC edge.
    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        bank_d   = bank_q;
        strobe_d = '0;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        aerr_d   = 1'b0;
        ovr_d    = 1'b0;
        valid_wr = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_end) begin
                    state_d = CAPTURE;
                    frame_d = shadow_reg;
                end
            end
            CAPTURE: begin
                state_d = EXEC;
                ovr_d   = frame_end;
                aerr_d  = 1'b1;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (frame_addr == 7'(i)) begin
                        aerr_d = 1'b0;
                        cnt_d  = cnt_q + 8'd1;
                        if (frame_rw) begin
                            bank_d[8*i +: 8] = frame_data;
                            strobe_d[i]      = 1'b1;
                            rd_d             = frame_data;
                            valid_wr         = 1'b1;
                        end else begin
                            rd_d = bank_q[8*i +: 8];
                        end
                    end
                end
            end
            EXEC: begin
                state_d = IDLE;
                ovr_d   = frame_end;
            end
            default: state_d = IDLE;
        endcase
        if (wdt_expire) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (WDT_CLR_MASK[i]) begin
                    bank_d[8*i +: 8] = 8'h00;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            frame_q  <= '0;
            bank_q   <= '0;
            strobe_q <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            aerr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            bank_q   <= bank_d;
            strobe_q <= strobe_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            aerr_q   <= aerr_d;
            ovr_q    <= ovr_d;
        end
    end

`ifdef SPI_WDT_EN
    logic [31:0] wdt_cnt_q;
    logic        wdt_to_q;

    // A valid write in the same cycle as expiry reloads instead of expiring.
    assign wdt_expire = ~valid_wr & (wdt_cnt_q == 32'd1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wdt_cnt_q <= 32'(WDT_CYCLES);
            wdt_to_q  <= 1'b0;
        end else if (valid_wr) begin
            wdt_cnt_q <= 32'(WDT_CYCLES);
            wdt_to_q  <= 1'b0;
        end else if (wdt_expire) begin
            wdt_cnt_q <= 32'd0;
            wdt_to_q  <= 1'b1;
        end else if (wdt_cnt_q != 32'd0) begin
            wdt_cnt_q <= wdt_cnt_q - 32'd1;
        end
    end

    assign wdt_timeout = wdt_to_q;
`else
    logic unused_wdt;

    assign wdt_expire  = 1'b0;
    assign wdt_timeout = 1'b0;
    assign unused_wdt  = ^{valid_wr, 32'(WDT_CYCLES), WDT_CLR_MASK};
`endif

    assign reg_out   = bank_q;
    assign wr_strobe = strobe_q;
    assign rd_data   = rd_q;
    assign frame_cnt = cnt_q;
    assign addr_err  = aerr_q;
    assign ovr_err   = ovr_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: directed vector table, overrun and reset corner cases,
// randomized frames against a register-bank model. Watchdog checks run when SPI_WDT_EN is defined.
module tb_spi_reg_ctrl;

    localparam int NR = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          cs_n;
    logic [15:0]   shadow_reg;
    logic [63:0]   reg_out;
    logic [NR-1:0] wr_strobe;
    logic [7:0]    rd_data;
    logic [7:0]    frame_cnt;
    logic          addr_err;
    logic          ovr_err;
    logic          wdt_timeout;

    int checkCount = 0;
    int passCount  = 0;
    int strobePulses = 0;
    int ovrPulses    = 0;

    logic [7:0] model [NR];
    logic [7:0] modelCnt;
    logic [7:0] modelRd;

    typedef struct {
        logic [15:0] shadow;
        logic [7:0]  expStrobe;
        logic [7:0]  expRd;
        logic        expAerr;
        logic [7:0]  expCnt;
        logic [63:0] expBank;
    } vec_t;

    vec_t vecs [9];

    spi_reg_ctrl #(.NUM_REGS(NR), .WDT_CYCLES(100)) dut (
        .clock       (clock),
        .reset       (reset),
        .cs_n        (cs_n),
        .shadow_reg  (shadow_reg),
        .reg_out     (reg_out),
        .wr_strobe   (wr_strobe),
        .rd_data     (rd_data),
        .frame_cnt   (frame_cnt),
        .addr_err    (addr_err),
        .ovr_err     (ovr_err),
        .wdt_timeout (wdt_timeout)
    );

    always #5 clock = ~clock;

    // Pulse counters make sure frames never produce extra or missing strobes.
    always @(posedge clock) begin
        if (|wr_strobe) strobePulses++;
        if (ovr_err) ovrPulses++;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    // Drives one frame; returns 1ns after edge E+3, where the result must be visible.
    task automatic applyStimulus(input logic [15:0] frame);
        @(negedge clock);
        cs_n = 1'b0;
        repeat (2) @(negedge clock);
        shadow_reg = frame;
        cs_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("strobe_before_E3", wr_strobe, 0);
        @(posedge clock);
        #1;
    endtask

    task automatic modelReset();
        for (int i = 0; i < NR; i++) model[i] = 8'h00;
        modelCnt = 8'h00;
        modelRd  = 8'h00;
    endtask

    task automatic modelApply(input logic [15:0] frame, output logic [7:0] expStrobe, output logic expAerr);
        int a;
        a = int'(frame[14:8]);
        expStrobe = 8'h00;
        expAerr   = 1'b0;
        if (a >= NR) begin
            expAerr = 1'b1;
        end else begin
            if (frame[15]) begin
                model[a]     = frame[7:0];
                expStrobe[a] = 1'b1;
                modelRd      = frame[7:0];
            end else begin
                modelRd = model[a];
            end
            modelCnt = modelCnt + 8'd1;
        end
    endtask

    function automatic logic [63:0] modelBank();
        logic [63:0] b;
        for (int i = 0; i < NR; i++) b[8*i +: 8] = model[i];
        return b;
    endfunction

    initial begin
        logic [7:0]  expStrobe;
        logic        expAerr;
        logic [15:0] frame;
        int          strobeBase;
        int          ovrBase;

        vecs[0] = '{16'h8355, 8'h08, 8'h55, 1'b0, 8'd1, 64'h00000000_55000000};
        vecs[1] = '{16'h0300, 8'h00, 8'h55, 1'b0, 8'd2, 64'h00000000_55000000};
        vecs[2] = '{16'h8A11, 8'h00, 8'h55, 1'b1, 8'd2, 64'h00000000_55000000};
        vecs[3] = '{16'h87C3, 8'h80, 8'hC3, 1'b0, 8'd3, 64'hC3000000_55000000};
        vecs[4] = '{16'h0700, 8'h00, 8'hC3, 1'b0, 8'd4, 64'hC3000000_55000000};
        vecs[5] = '{16'h0000, 8'h00, 8'h00, 1'b0, 8'd5, 64'hC3000000_55000000};
        vecs[6] = '{16'h8801, 8'h00, 8'h00, 1'b1, 8'd5, 64'hC3000000_55000000};
        vecs[7] = '{16'hFF00, 8'h00, 8'h00, 1'b1, 8'd5, 64'hC3000000_55000000};
        vecs[8] = '{16'h8001, 8'h01, 8'h01, 1'b0, 8'd6, 64'hC3000000_55000001};

        reset = 1'b1;
        cs_n = 1'b1;
        shadow_reg = 16'h0000;
        modelReset();
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_reg_out", reg_out, 0);
        checkOutput("reset_frame_cnt", frame_cnt, 0);
        checkOutput("reset_rd_data", rd_data, 0);
        checkOutput("reset_pulses", {wr_strobe, addr_err, ovr_err, wdt_timeout}, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        checkOutput("idle_frame_cnt", frame_cnt, 0);
        checkOutput("idle_strobes", strobePulses, 0);
        checkOutput("idle_reg_out", reg_out, 0);

        $display("[TB] directed vector table");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].shadow);
            modelApply(vecs[i].shadow, expStrobe, expAerr);
            checkOutput("vec_wr_strobe", wr_strobe, vecs[i].expStrobe);
            checkOutput("vec_rd_data", rd_data, vecs[i].expRd);
            checkOutput("vec_addr_err", addr_err, vecs[i].expAerr);
            checkOutput("vec_frame_cnt", frame_cnt, vecs[i].expCnt);
            checkOutput("vec_reg_out", reg_out, vecs[i].expBank);
            @(posedge clock);
            #1;
            checkOutput("vec_pulse_end", {wr_strobe, addr_err}, 0);
        end

        $display("[TB] overrun sequence");
        strobeBase = strobePulses;
        ovrBase = ovrPulses;
        @(negedge clock);
        cs_n = 1'b0;
        repeat (2) @(negedge clock);
        shadow_reg = 16'h8142;
        cs_n = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cs_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        cs_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        modelApply(16'h8142, expStrobe, expAerr);
        checkOutput("ovr_first_strobe", wr_strobe, expStrobe);
        @(posedge clock);
        #1;
        checkOutput("ovr_pulse", ovr_err, 1);
        @(posedge clock);
        #1;
        checkOutput("ovr_pulse_end", ovr_err, 0);
        repeat (8) @(posedge clock);
        #1;
        checkOutput("ovr_frame_cnt", frame_cnt, modelCnt);
        checkOutput("ovr_strobe_count", strobePulses - strobeBase, 1);
        checkOutput("ovr_pulse_count", ovrPulses - ovrBase, 1);
        checkOutput("ovr_reg_out", reg_out, modelBank());

        $display("[TB] randomized frames");
        for (int i = 0; i < 40; i++) begin
            logic [6:0] a;
            logic       rw;
            logic [7:0] d;
            a  = 7'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0) a = 7'($urandom_range(8, 127));
            rw = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
`ifdef SPI_WDT_EN
            if (i % 2 == 0) begin
                rw = 1'b1;
                a  = 7'($urandom_range(0, NR - 1));
            end
`endif
            frame = {rw, a, d};
            applyStimulus(frame);
            modelApply(frame, expStrobe, expAerr);
            checkOutput("rnd_reg_out", reg_out, modelBank());
            checkOutput("rnd_rd_data", rd_data, modelRd);
            checkOutput("rnd_frame_cnt", frame_cnt, modelCnt);
            checkOutput("rnd_wr_strobe", wr_strobe, expStrobe);
            checkOutput("rnd_addr_err", addr_err, expAerr);
            @(posedge clock);
            #1;
            checkOutput("rnd_pulse_end", {wr_strobe, addr_err}, 0);
        end

`ifdef SPI_WDT_EN
        $display("[TB] watchdog expiry");
        applyStimulus(16'h80AA);
        modelApply(16'h80AA, expStrobe, expAerr);
        checkOutput("wdt_reg0_written", reg_out[7:0], 8'hAA);
        repeat (99) @(posedge clock);
        #1;
        checkOutput("wdt_not_yet", wdt_timeout, 0);
        checkOutput("wdt_reg_before", reg_out, modelBank());
        @(posedge clock);
        #1;
        for (int i = 0; i < NR; i++) model[i] = 8'h00;
        checkOutput("wdt_timeout_set", wdt_timeout, 1);
        checkOutput("wdt_regs_cleared", reg_out, modelBank());
        repeat (5) @(posedge clock);
        #1;
        checkOutput("wdt_sticky", wdt_timeout, 1);
        applyStimulus(16'h8122);
        modelApply(16'h8122, expStrobe, expAerr);
        checkOutput("wdt_cleared_by_write", wdt_timeout, 0);
        checkOutput("wdt_write_after", reg_out, modelBank());
`else
        $display("[TB] no watchdog activity");
        repeat (120) @(posedge clock);
        #1;
        checkOutput("nowdt_timeout", wdt_timeout, 0);
        checkOutput("nowdt_reg_out", reg_out, modelBank());
`endif

        $display("[TB] reset during CAPTURE");
        strobeBase = strobePulses;
        @(negedge clock);
        cs_n = 1'b0;
        repeat (2) @(negedge clock);
        shadow_reg = 16'h8477;
        cs_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        #3;
        reset = 1'b0;
        modelReset();
        repeat (6) @(posedge clock);
        #1;
        checkOutput("rstcap_reg_out", reg_out, 0);
        checkOutput("rstcap_frame_cnt", frame_cnt, 0);
        checkOutput("rstcap_rd_data", rd_data, 0);
        checkOutput("rstcap_flags", {addr_err, ovr_err, wdt_timeout}, 0);
        checkOutput("rstcap_no_strobe", strobePulses - strobeBase, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
